// File: rtl/calc3_port_issuer.sv
// Issue stage for one calc3 command port: allocates 2-bit tags, drives one-cycle
// requests, matches responses back to tags and reports completions or timeouts.
module calc3_port_issuer #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT         = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_cmd,
   input  logic [3:0]  in_d1,
   input  logic [3:0]  in_d2,
   input  logic [3:0]  in_r1,
   input  logic [31:0] in_data,
   output logic [3:0]  req_cmd,
   output logic [3:0]  req_d1,
   output logic [3:0]  req_d2,
   output logic [3:0]  req_r1,
   output logic [31:0] req_data,
   output logic [1:0]  req_tag,
   input  logic [1:0]  out_resp,
   input  logic [31:0] out_data,
   input  logic [1:0]  out_tag,
   output logic        cpl_valid,
   output logic [1:0]  cpl_resp,
   output logic [31:0] cpl_data,
   output logic [1:0]  cpl_tag,
   output logic [3:0]  cpl_cmd,
   output logic [2:0]  outstanding,
   output logic        spurious_err
);

   localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TC    = TW'(TIMEOUT - 1);
   localparam logic [2:0]    MAX_O = 3'(MAX_OUTSTANDING);

   logic [3:0]    busy;
   logic [3:0]    cmd_tbl [4];
   logic [TW-1:0] timer   [4];

   logic       accept;
   logic       issue;
   logic [1:0] alloc_tag;
   logic [3:0] alloc_mask;
   logic       resp_hit;
   logic       resp_spur;
   logic [3:0] tmo_cand;
   logic       cpl_fire;
   logic       cpl_is_tmo;
   logic [1:0] cpl_sel;
   logic [3:0] free_mask;

   // Ready depends only on registered state, and is forced low while in reset.
   assign in_ready = reset && (outstanding < MAX_O) && (busy != 4'hf);
   assign accept   = in_valid && in_ready;
   assign issue    = accept && (in_cmd != 4'd0);

   assign resp_hit  = (out_resp != 2'd0) &&  busy[out_tag];
   assign resp_spur = (out_resp != 2'd0) && !busy[out_tag];

   always_comb begin
      alloc_tag = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!busy[i]) alloc_tag = 2'(i);
      end
      alloc_mask = issue ? (4'b0001 << alloc_tag) : 4'b0000;
   end

   // A response on a tag that has just reached terminal count beats its timeout.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         tmo_cand[i] = busy[i] && (timer[i] == TC) && !(resp_hit && (out_tag == 2'(i)));
      end
   end

   always_comb begin
      cpl_fire   = 1'b0;
      cpl_is_tmo = 1'b0;
      cpl_sel    = 2'd0;
      if (resp_hit) begin
         cpl_fire = 1'b1;
         cpl_sel  = out_tag;
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (tmo_cand[i]) begin
               cpl_fire   = 1'b1;
               cpl_is_tmo = 1'b1;
               cpl_sel    = 2'(i);
            end
         end
      end
      free_mask = cpl_fire ? (4'b0001 << cpl_sel) : 4'b0000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy         <= 4'b0000;
         outstanding  <= 3'd0;
         spurious_err <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cmd_tbl[i] <= 4'd0;
            timer[i]   <= '0;
         end
      end else begin
         busy        <= (busy & ~free_mask) | alloc_mask;
         outstanding <= outstanding + 3'(issue) - 3'(cpl_fire);
         if (resp_spur) spurious_err <= 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (alloc_mask[i]) begin
               cmd_tbl[i] <= in_cmd;
               timer[i]   <= '0;
            end else if (busy[i] && (timer[i] != TC)) begin
               timer[i] <= timer[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_cmd  <= 4'd0;
         req_d1   <= 4'd0;
         req_d2   <= 4'd0;
         req_r1   <= 4'd0;
         req_data <= 32'd0;
         req_tag  <= 2'd0;
      end else if (issue) begin
         req_cmd  <= in_cmd;
         req_d1   <= in_d1;
         req_d2   <= in_d2;
         req_r1   <= in_r1;
         req_data <= in_data;
         req_tag  <= alloc_tag;
      end else begin
         req_cmd  <= 4'd0;
         req_d1   <= 4'd0;
         req_d2   <= 4'd0;
         req_r1   <= 4'd0;
         req_data <= 32'd0;
         req_tag  <= 2'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpl_valid <= 1'b0;
         cpl_resp  <= 2'd0;
         cpl_data  <= 32'd0;
         cpl_tag   <= 2'd0;
         cpl_cmd   <= 4'd0;
      end else if (cpl_fire) begin
         cpl_valid <= 1'b1;
         cpl_resp  <= cpl_is_tmo ? 2'd3 : out_resp;
         cpl_data  <= cpl_is_tmo ? 32'd0 : out_data;
         cpl_tag   <= cpl_sel;
         cpl_cmd   <= cmd_tbl[cpl_sel];
      end else begin
         cpl_valid <= 1'b0;
         cpl_resp  <= 2'd0;
         cpl_data  <= 32'd0;
         cpl_tag   <= 2'd0;
         cpl_cmd   <= 4'd0;
      end
   end

endmodule

// File: tb/tb_calc3_port_issuer.sv
// Directed bench for calc3_port_issuer: issue, response, back-pressure, timeout,
// free/allocate ordering and mid-flight reset.
module tb_calc3_port_issuer;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [3:0]  in_cmd, in_d1, in_d2, in_r1;
   logic [31:0] in_data;
   logic [3:0]  req_cmd, req_d1, req_d2, req_r1;
   logic [31:0] req_data;
   logic [1:0]  req_tag;
   logic [1:0]  out_resp, out_tag;
   logic [31:0] out_data;
   logic        cpl_valid;
   logic [1:0]  cpl_resp, cpl_tag;
   logic [31:0] cpl_data;
   logic [3:0]  cpl_cmd;
   logic [2:0]  outstanding;
   logic        spurious_err;

   int n_chk = 0;
   int n_err = 0;

   calc3_port_issuer #(.MAX_OUTSTANDING(4), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
      .in_d1(in_d1), .in_d2(in_d2), .in_r1(in_r1), .in_data(in_data),
      .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
      .req_data(req_data), .req_tag(req_tag),
      .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
      .cpl_valid(cpl_valid), .cpl_resp(cpl_resp), .cpl_data(cpl_data),
      .cpl_tag(cpl_tag), .cpl_cmd(cpl_cmd),
      .outstanding(outstanding), .spurious_err(spurious_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      in_valid = 1'b0;
      in_cmd   = 4'd0;
      out_resp = 2'd0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   logic [3:0] cmds [4];
   int n;

   initial begin
      cmds[0] = 4'd1; cmds[1] = 4'd2; cmds[2] = 4'd5; cmds[3] = 4'd6;
      reset = 1'b0; in_valid = 1'b1; in_cmd = 4'd1;
      in_d1 = 4'd0; in_d2 = 4'd0; in_r1 = 4'd0; in_data = 32'd0;
      out_resp = 2'd0; out_tag = 2'd0; out_data = 32'd0;

      // reset holds everything quiet even with a command offered
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_ready", in_ready, 0);
         chk("rst_req", req_cmd, 0);
         chk("rst_cpl", cpl_valid, 0);
      end
      chk("rst_outst", outstanding, 0);
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      chk("rel_ready", in_ready, 1);
      step();

      // single add round trip
      in_valid = 1'b1; in_cmd = 4'd1; in_d1 = 4'd1; in_d2 = 4'd2; in_r1 = 4'd3; in_data = 32'h11;
      step();
      in_valid = 1'b0;
      chk("t2_req_cmd", req_cmd, 1);
      chk("t2_req_tag", req_tag, 0);
      chk("t2_req_ops", {req_d1, req_d2, req_r1}, 12'h123);
      chk("t2_req_data", req_data, 32'h11);
      chk("t2_outst1", outstanding, 1);
      step();
      chk("t2_req_once", req_cmd, 0);
      out_resp = 2'd1; out_tag = 2'd0; out_data = 32'h5;
      step();
      out_resp = 2'd0;
      chk("t2_cpl_v", cpl_valid, 1);
      chk("t2_cpl_cmd", cpl_cmd, 1);
      chk("t2_cpl_data", cpl_data, 32'h5);
      chk("t2_cpl_resp", cpl_resp, 1);
      chk("t2_cpl_tag", cpl_tag, 0);
      chk("t2_outst0", outstanding, 0);
      // no-op command is accepted but issues nothing
      in_valid = 1'b1; in_cmd = 4'd0;
      chk("t2_nop_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("t2_cpl_once", cpl_valid, 0);
      chk("t2_nop_req", req_cmd, 0);
      chk("t2_nop_outst", outstanding, 0);

      // fill all four tags, then free tag2 to let the fifth through
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_cmd = cmds[i];
         chk("t3_rdy", in_ready, 1);
         step();
         chk("t3_tag", req_tag, 32'(i));
         chk("t3_cmd", req_cmd, cmds[i]);
      end
      in_cmd = 4'd2;
      chk("t3_full_rdy", in_ready, 0);
      chk("t3_outst4", outstanding, 4);
      out_resp = 2'd2; out_tag = 2'd2; out_data = 32'hAA;
      step();
      out_resp = 2'd0;
      chk("t3_cpl_v", cpl_valid, 1);
      chk("t3_cpl_tag", cpl_tag, 2);
      chk("t3_cpl_cmd", cpl_cmd, 5);
      chk("t3_cpl_resp", cpl_resp, 2);
      chk("t3_cpl_data", cpl_data, 32'hAA);
      chk("t3_outst3", outstanding, 3);
      chk("t3_rdy_again", in_ready, 1);
      chk("t3_no_req", req_cmd, 0);
      step();
      in_valid = 1'b0;
      chk("t3_5th_tag", req_tag, 2);
      chk("t3_5th_cmd", req_cmd, 2);
      chk("t3_outst4b", outstanding, 4);

      // timeout then late response
      do_reset();
      in_valid = 1'b1; in_cmd = 4'd6;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!cpl_valid && n < 100) begin
         step();
         n++;
      end
      chk("t4_tmo_cycles", n, TMO);
      chk("t4_resp", cpl_resp, 3);
      chk("t4_data", cpl_data, 0);
      chk("t4_tag", cpl_tag, 0);
      chk("t4_cmd", cpl_cmd, 6);
      chk("t4_outst", outstanding, 0);
      chk("t4_spur0", spurious_err, 0);
      out_resp = 2'd1; out_tag = 2'd0; out_data = 32'h9;
      step();
      out_resp = 2'd0;
      chk("t4_late_cpl", cpl_valid, 0);
      chk("t4_spur1", spurious_err, 1);
      step();
      chk("t4_spur_sticky", spurious_err, 1);

      // response arriving on the terminal-count cycle wins over the timeout
      do_reset();
      in_valid = 1'b1; in_cmd = 4'd1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < TMO - 1; i++) step();
      out_resp = 2'd1; out_tag = 2'd0; out_data = 32'h7;
      step();
      out_resp = 2'd0;
      chk("t4b_cpl_v", cpl_valid, 1);
      chk("t4b_resp", cpl_resp, 1);
      chk("t4b_data", cpl_data, 32'h7);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4b_no_tmo", cpl_valid, 0);
      end
      chk("t4b_spur", spurious_err, 0);

      // freed tag is not reused in its freeing cycle
      do_reset();
      in_valid = 1'b1; in_cmd = 4'd1;
      step();
      in_cmd = 4'd2;
      step();
      chk("t5_tag1", req_tag, 1);
      in_cmd = 4'd5;
      out_resp = 2'd1; out_tag = 2'd1; out_data = 32'h21;
      chk("t5_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      out_resp = 2'd2; out_tag = 2'd0; out_data = 32'h20;
      chk("t5_new_tag", req_tag, 2);
      chk("t5_new_cmd", req_cmd, 5);
      chk("t5_cpl1_tag", cpl_tag, 1);
      chk("t5_cpl1_cmd", cpl_cmd, 2);
      chk("t5_cpl1_data", cpl_data, 32'h21);
      chk("t5_outst2", outstanding, 2);
      step();
      out_resp = 2'd0;
      chk("t5_cpl0_v", cpl_valid, 1);
      chk("t5_cpl0_tag", cpl_tag, 0);
      chk("t5_cpl0_cmd", cpl_cmd, 1);
      chk("t5_cpl0_resp", cpl_resp, 2);
      chk("t5_outst1", outstanding, 1);

      // reset with three tags in flight
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_cmd = cmds[i];
         step();
      end
      in_valid = 1'b0;
      chk("t6_outst3", outstanding, 3);
      reset = 1'b0;
      #1;
      chk("t6_rst_outst", outstanding, 0);
      chk("t6_rst_req", req_cmd, 0);
      chk("t6_rst_rdy", in_ready, 0);
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < TMO + 4; i++) begin
         step();
         if (cpl_valid) chk("t6_no_cpl", cpl_valid, 0);
      end
      chk("t6_quiet", cpl_valid, 0);
      in_valid = 1'b1; in_cmd = 4'd6;
      step();
      in_valid = 1'b0;
      chk("t6_tag0", req_tag, 0);
      chk("t6_cmd", req_cmd, 6);
      chk("t6_outst1", outstanding, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
